// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared encodings for the multi-cycle RV32I control unit:
//               FSM state codes, opcode constants, ALU operation codes,
//               ALU-B / PC-source select codes and the decode flag bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    // FSM state encodings (also driven out on the state port)
    localparam logic [2:0] c_S_IF  = 3'd0;
    localparam logic [2:0] c_S_ID  = 3'd1;
    localparam logic [2:0] c_S_EXE = 3'd2;
    localparam logic [2:0] c_S_MEM = 3'd3;
    localparam logic [2:0] c_S_WB  = 3'd4;

    // Major opcodes
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    // ALU operation codes
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_LUI  = 4'b0010;
    localparam logic [3:0] c_ALU_HAMD = 4'b1111;

    // ALU B operand select
    localparam logic [1:0] c_ALUB_RS2  = 2'b00;
    localparam logic [1:0] c_ALUB_FOUR = 2'b01;
    localparam logic [1:0] c_ALUB_IMM  = 2'b10;

    // PC source select
    localparam logic [1:0] c_PCS_ALU  = 2'b00;
    localparam logic [1:0] c_PCS_TGT  = 2'b01;
    localparam logic [1:0] c_PCS_JALR = 2'b10;

    // One-hot instruction flags; 'illegal' is the LSB and is set when
    // none of the other flags matched.
    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_hamd;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_slli;
        logic i_srli;
        logic i_srai;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_lui;
        logic i_jal;
        logic i_jalr;
        logic illegal;
    } dec_t;

    // ALU code for the register/immediate arithmetic class
    function automatic logic [3:0] f_alu_op(input dec_t d);
        logic [3:0] v_op;
        v_op = c_ALU_ADD;
        if (d.i_sub)                 v_op = c_ALU_SUB;
        if (d.i_and  | d.i_andi)     v_op = c_ALU_AND;
        if (d.i_or   | d.i_ori)      v_op = c_ALU_OR;
        if (d.i_xor  | d.i_xori)     v_op = c_ALU_XOR;
        if (d.i_sll  | d.i_slli)     v_op = c_ALU_SLL;
        if (d.i_srl  | d.i_srli)     v_op = c_ALU_SRL;
        if (d.i_sra  | d.i_srai)     v_op = c_ALU_SRA;
        if (d.i_hamd)                v_op = c_ALU_HAMD;
        return v_op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_cu_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_cu_if
// Description : Control bus between the multi-cycle CU and its datapath /
//               memory. master = control unit, slave = datapath side.
//   inst     : IR contents             z        : ALU zero flag
//   mem_ack  : memory completes access mem_req  : memory request
//   iord/wmem/wir/wpc/wtgt/wreg/m2reg/link/alua/alub/aluc/pcsource/sext/
//   shift    : datapath controls       ill/mem_err : error pulses
//   state    : current FSM state
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_cu_if;
    logic [31:0] inst;
    logic        z;
    logic        mem_ack;
    logic        mem_req;
    logic        iord;
    logic        wmem;
    logic        wir;
    logic        wpc;
    logic        wtgt;
    logic        wreg;
    logic        m2reg;
    logic        link;
    logic        alua;
    logic [1:0]  alub;
    logic [3:0]  aluc;
    logic [1:0]  pcsource;
    logic        sext;
    logic        shift;
    logic        ill;
    logic        mem_err;
    logic [2:0]  state;

    modport master (
        input  inst, z, mem_ack,
        output mem_req, iord, wmem, wir, wpc, wtgt, wreg, m2reg, link,
               alua, alub, aluc, pcsource, sext, shift, ill, mem_err, state
    );

    modport slave (
        output inst, z, mem_ack,
        input  mem_req, iord, wmem, wir, wpc, wtgt, wreg, m2reg, link,
               alua, alub, aluc, pcsource, sext, shift, ill, mem_err, state
    );
endinterface
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Combinational RV32I-subset decoder: instruction word to
//               one-hot flags plus an illegal flag.
//   i_inst : instruction register contents
//   o_dec  : one-hot decode flags (mc_pkg::dec_t)
// Config      : MC_CU_HAMD_EN - decode R-type funct3=111/funct7=0100000 as hamd
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  wire logic [31:0] i_inst,
    output dec_t             o_dec
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_f7_zero;
    logic       w_f7_alt;
    logic       w_unused_bits;

    assign w_op      = i_inst[6:0];
    assign w_f3      = i_inst[14:12];
    assign w_f7      = i_inst[31:25];
    assign w_f7_zero = (w_f7 == 7'b0000000);
    assign w_f7_alt  = (w_f7 == 7'b0100000);
    // register / immediate fields do not affect the control decode
    assign w_unused_bits = ^{i_inst[24:15], i_inst[11:7]};

    always_comb begin
        o_dec = '0;
        case (w_op)
            c_OP_R: begin
                case (w_f3)
                    3'b000: begin
                        o_dec.i_add = w_f7_zero;
                        o_dec.i_sub = w_f7_alt;
                    end
                    3'b001: o_dec.i_sll = w_f7_zero;
                    3'b100: o_dec.i_xor = w_f7_zero;
                    3'b101: begin
                        o_dec.i_srl = w_f7_zero;
                        o_dec.i_sra = w_f7_alt;
                    end
                    3'b110: o_dec.i_or  = w_f7_zero;
                    3'b111: begin
                        o_dec.i_and = w_f7_zero;
`ifdef MC_CU_HAMD_EN
                        o_dec.i_hamd = w_f7_alt;
`else
                        o_dec.i_hamd = 1'b0;
`endif
                    end
                    default: ;
                endcase
            end
            c_OP_I: begin
                case (w_f3)
                    3'b000: o_dec.i_addi = 1'b1;
                    3'b111: o_dec.i_andi = 1'b1;
                    3'b110: o_dec.i_ori  = 1'b1;
                    3'b100: o_dec.i_xori = 1'b1;
                    3'b001: o_dec.i_slli = w_f7_zero;
                    3'b101: begin
                        o_dec.i_srli = w_f7_zero;
                        o_dec.i_srai = w_f7_alt;
                    end
                    default: ;
                endcase
            end
            c_OP_LOAD:   o_dec.i_lw   = (w_f3 == 3'b010);
            c_OP_STORE:  o_dec.i_sw   = (w_f3 == 3'b010);
            c_OP_BRANCH: begin
                o_dec.i_beq = (w_f3 == 3'b000);
                o_dec.i_bne = (w_f3 == 3'b001);
            end
            c_OP_LUI:    o_dec.i_lui  = 1'b1;
            c_OP_JAL:    o_dec.i_jal  = 1'b1;
            c_OP_JALR:   o_dec.i_jalr = (w_f3 == 3'b000);
            default: ;
        endcase
        o_dec.illegal = (o_dec[$bits(dec_t)-1:1] == '0);
    end

endmodule
`default_nettype wire

// File: rtl/mc_cu.sv
`default_nettype none
// ============================================================================
// Module      : mc_cu
// Description : Multi-cycle control FSM (IF/ID/EXE/MEM/WB) for the RV32I
//               subset datapath. Shares one ALU and one memory port, with a
//               req/ack memory handshake and an optional wait timeout.
//   clock    : rising-edge clock
//   resetn   : synchronous active-low reset
//   bus      : mc_cu_if.master - inst/z/mem_ack in, all controls out
// Parameter   : WAIT_LIMIT - max memory wait cycles (0 = wait forever)
// Config      : MC_CU_HAMD_EN - enables the hamd R-type operation
// Revision    : 1.0 - initial release
// ============================================================================
module mc_cu
    import mc_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  wire logic clock,
    input  wire logic resetn,
    mc_cu_if.master   bus
);

    localparam int c_WCNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [c_WCNT_W-1:0] c_WLIM = c_WCNT_W'(WAIT_LIMIT);

    dec_t                w_dec;
    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic                r_run;     // low in the cycle after a reset edge
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_WCNT_W-1:0] w_wcnt_nxt;

    logic w_memst, w_timeout, w_alu_r, w_alu_i;
    logic w_mem_req, w_iord, w_wmem, w_wir, w_wpc, w_wtgt, w_wreg;
    logic w_m2reg, w_link, w_alua, w_sext, w_shift, w_ill, w_mem_err;
    logic [1:0] w_alub, w_pcsource;
    logic [3:0] w_aluc;

    mc_decode u_decode (
        .i_inst (bus.inst),
        .o_dec  (w_dec)
    );

    assign w_alu_r = w_dec.i_add | w_dec.i_sub | w_dec.i_and | w_dec.i_or |
                     w_dec.i_xor | w_dec.i_sll | w_dec.i_srl | w_dec.i_sra |
                     w_dec.i_hamd;
    assign w_alu_i = w_dec.i_addi | w_dec.i_andi | w_dec.i_ori | w_dec.i_xori |
                     w_dec.i_slli | w_dec.i_srli | w_dec.i_srai;

    assign w_memst   = (r_state == c_S_IF) || (r_state == c_S_MEM);
    // the abort cycle is the first one in which the counter sits at the limit
    assign w_timeout = (WAIT_LIMIT != 0) && w_memst && (r_wcnt == c_WLIM);

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_iord     = 1'b0;
        w_wmem     = 1'b0;
        w_wir      = 1'b0;
        w_wpc      = 1'b0;
        w_wtgt     = 1'b0;
        w_wreg     = 1'b0;
        w_m2reg    = 1'b0;
        w_link     = 1'b0;
        w_alua     = 1'b0;
        w_alub     = c_ALUB_RS2;
        w_aluc     = c_ALU_ADD;
        w_pcsource = c_PCS_ALU;
        w_sext     = 1'b0;
        w_shift    = 1'b0;
        w_ill      = 1'b0;
        w_mem_err  = 1'b0;
        case (r_state)
            c_S_IF: begin
                w_mem_req = ~w_timeout;
                w_alua    = 1'b1;
                w_alub    = c_ALUB_FOUR;
                if (w_timeout) begin
                    w_mem_err = 1'b1;
                end else if (bus.mem_ack) begin
                    w_wir  = 1'b1;
                    w_wpc  = 1'b1;
                    w_next = c_S_ID;
                end
            end
            c_S_ID: begin
                w_alua = 1'b1;
                w_alub = c_ALUB_IMM;
                w_sext = 1'b1;
                if (w_dec.illegal) begin
                    w_ill  = 1'b1;
                    w_next = c_S_IF;
                end else begin
                    w_wtgt = 1'b1;
                    w_next = c_S_EXE;
                end
            end
            c_S_EXE: begin
                w_next = c_S_IF;
                if (w_alu_r) begin
                    w_aluc = f_alu_op(w_dec);
                    w_next = c_S_WB;
                end
                if (w_alu_i) begin
                    w_alub  = c_ALUB_IMM;
                    w_aluc  = f_alu_op(w_dec);
                    w_sext  = 1'b1;
                    w_shift = w_dec.i_slli | w_dec.i_srli | w_dec.i_srai;
                    w_next  = c_S_WB;
                end
                if (w_dec.i_lui) begin
                    w_alub = c_ALUB_IMM;
                    w_aluc = c_ALU_LUI;
                    w_next = c_S_WB;
                end
                if (w_dec.i_lw | w_dec.i_sw) begin
                    w_alub = c_ALUB_IMM;
                    w_sext = 1'b1;
                    w_next = c_S_MEM;
                end
                if (w_dec.i_beq | w_dec.i_bne) begin
                    w_aluc     = c_ALU_SUB;
                    w_pcsource = c_PCS_TGT;
                    w_wpc      = (w_dec.i_beq & bus.z) | (w_dec.i_bne & ~bus.z);
                end
                if (w_dec.i_jal) begin
                    w_wpc      = 1'b1;
                    w_pcsource = c_PCS_TGT;
                    w_wreg     = 1'b1;
                    w_link     = 1'b1;
                end
                if (w_dec.i_jalr) begin
                    w_alub     = c_ALUB_IMM;
                    w_sext     = 1'b1;
                    w_wpc      = 1'b1;
                    w_pcsource = c_PCS_JALR;
                    w_wreg     = 1'b1;
                    w_link     = 1'b1;
                end
            end
            c_S_MEM: begin
                w_mem_req = ~w_timeout;
                w_iord    = 1'b1;
                w_wmem    = w_dec.i_sw & ~w_timeout;
                if (w_timeout) begin
                    w_mem_err = 1'b1;
                    w_next    = c_S_IF;
                end else if (bus.mem_ack) begin
                    w_next = w_dec.i_lw ? c_S_WB : c_S_IF;
                end
            end
            c_S_WB: begin
                w_wreg  = 1'b1;
                w_m2reg = w_dec.i_lw;
                w_next  = c_S_IF;
            end
            default: w_next = c_S_IF;
        endcase
        // hold in IF until the cycle after reset is released
        if (!r_run) begin
            w_next = c_S_IF;
        end
    end

    // counts unacknowledged request cycles; any ack, abort or state change clears it
    assign w_wcnt_nxt = ((WAIT_LIMIT != 0) && r_run && w_memst && !bus.mem_ack && !w_timeout)
                        ? r_wcnt + 1'b1 : '0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= c_S_IF;
            r_run   <= 1'b0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    assign bus.mem_req  = r_run & w_mem_req;
    assign bus.iord     = r_run & w_iord;
    assign bus.wmem     = r_run & w_wmem;
    assign bus.wir      = r_run & w_wir;
    assign bus.wpc      = r_run & w_wpc;
    assign bus.wtgt     = r_run & w_wtgt;
    assign bus.wreg     = r_run & w_wreg;
    assign bus.m2reg    = r_run & w_m2reg;
    assign bus.link     = r_run & w_link;
    assign bus.alua     = r_run & w_alua;
    assign bus.alub     = r_run ? w_alub     : 2'b00;
    assign bus.aluc     = r_run ? w_aluc     : 4'b0000;
    assign bus.pcsource = r_run ? w_pcsource : 2'b00;
    assign bus.sext     = r_run & w_sext;
    assign bus.shift    = r_run & w_shift;
    assign bus.ill      = r_run & w_ill;
    assign bus.mem_err  = r_run & w_mem_err;
    assign bus.state    = r_state;

endmodule
`default_nettype wire
